// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one UART transmitter among NUM_REQ requesters.
// Optional build macro UART_TX_SCHED_TIMEOUT_EN adds a WAIT-state watchdog; without it
// WAIT waits indefinitely and timeout_err is held at 0. The port list is the same in both builds.
//
// state | meaning
// IDLE  | no transfer; arbitrate among pending requests
// START | one-cycle active-low start strobe to the transmitter
// WAIT  | byte in flight, waiting for tx_complete (or watchdog expiry)
// DONE  | one-cycle ack to the granted requester, then back to IDLE
module uart_tx_sched #(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [8*NUM_REQ-1:0]         req_byte,
   output logic [NUM_REQ-1:0]           ack,
   output logic [$clog2(NUM_REQ)-1:0]   grant_id,
   output logic                         busy,
   output logic                         tx_en,
   output logic [7:0]                   tx_byte,
   input  logic                         tx_complete,
   output logic                         timeout_err
);

   localparam int IDW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

   state_t               state, state_nxt;
   logic [IDW-1:0]       last_grant, last_grant_nxt;
   logic [IDW-1:0]       idx, pick;
   logic                 pick_valid;
   logic [7:0]           pick_byte;
   logic                 timeout_hit;
   logic                 tx_en_nxt, busy_nxt;
   logic [7:0]           tx_byte_nxt;
   logic [NUM_REQ-1:0]   ack_nxt;
   logic [IDW-1:0]       grant_id_nxt;

   // Round-robin pick: first pending request after last_grant, wrapping around.
   always_comb begin
      idx        = '0;
      pick       = '0;
      pick_valid = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = IDW'((int'(last_grant) + k) % NUM_REQ);
         if (!pick_valid && req[idx]) begin
            pick_valid = 1'b1;
            pick       = idx;
         end
      end
   end

   // Byte of the picked requester, selected with constant slices.
   always_comb begin
      pick_byte = 8'h00;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (IDW'(i) == pick) pick_byte = req_byte[8*i +: 8];
      end
   end

`ifdef UART_TX_SCHED_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] to_cnt;

   // Watchdog down-counter: loaded when entering WAIT, terminal count at zero.
   always_ff @(posedge clk) begin
      if (reset)                             to_cnt <= '0;
      else if (state == S_START)             to_cnt <= CW'(TIMEOUT_CYCLES - 1);
      else if (state == S_WAIT && to_cnt != '0) to_cnt <= to_cnt - CW'(1);
   end

   assign timeout_hit = (state == S_WAIT) && (to_cnt == '0);

   // Sticky error: set when the watchdog abandons a transfer, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset)                            timeout_err <= 1'b0;
      else if (timeout_hit && !tx_complete) timeout_err <= 1'b1;
   end
`else
   localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;

   assign timeout_hit = 1'b0;
   assign timeout_err = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic; tx_complete only matters in WAIT and wins over a same-cycle timeout.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (pick_valid) state_nxt = S_START;
         S_START: state_nxt = S_WAIT;
         S_WAIT:  begin
            if (tx_complete)      state_nxt = S_DONE;
            else if (timeout_hit) state_nxt = S_IDLE;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Next values of the registered outputs; grant and byte are latched only in IDLE.
   always_comb begin
      tx_en_nxt      = 1'b1;
      tx_byte_nxt    = tx_byte;
      grant_id_nxt   = grant_id;
      ack_nxt        = '0;
      last_grant_nxt = last_grant;
      busy_nxt       = (state_nxt != S_IDLE);
      case (state)
         S_IDLE: begin
            if (pick_valid) begin
               tx_en_nxt    = 1'b0;
               tx_byte_nxt  = pick_byte;
               grant_id_nxt = pick;
            end
         end
         S_WAIT: begin
            if (tx_complete)      ack_nxt[grant_id] = 1'b1;
            else if (timeout_hit) last_grant_nxt    = grant_id;
         end
         S_DONE:  last_grant_nxt = grant_id;
         default: ;
      endcase
   end

   // Output and arbitration-pointer registers; reset leaves requester 0 first in line.
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_en      <= 1'b1;
         tx_byte    <= 8'h00;
         grant_id   <= '0;
         ack        <= '0;
         busy       <= 1'b0;
         last_grant <= IDW'(NUM_REQ - 1);
      end else begin
         tx_en      <= tx_en_nxt;
         tx_byte    <= tx_byte_nxt;
         grant_id   <= grant_id_nxt;
         ack        <= ack_nxt;
         busy       <= busy_nxt;
         last_grant <= last_grant_nxt;
      end
   end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requesters sharing one UART transmitter (2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 4096, SHALL set the WAIT-state watchdog limit in clk cycles.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-005 req  input  NUM_REQ  SHALL carry the level request per requester; bit i means requester i has a byte pending.
REQ-006 req_byte  input  8*NUM_REQ  SHALL carry the flattened bytes; bits [8i+7:8i] belong to requester i.
REQ-007 ack  output  NUM_REQ  SHALL carry the one-cycle pulse to requester i when its byte has been sent.
REQ-008 grant_id  output  $clog2(NUM_REQ)  SHALL carry the index of the requester currently owning the transmitter.
REQ-009 busy  output  1  SHALL be high whenever state is not IDLE.
REQ-010 tx_en  output  1  SHALL be the active-low start strobe to the UART transmitter; 1 = idle.
REQ-011 tx_byte  output  8  SHALL carry the byte presented to the UART transmitter.
REQ-012 tx_complete  input  1  SHALL be the one-cycle done pulse from the UART transmitter.
REQ-013 timeout_err  output  1  SHALL be the sticky watchdog error flag.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, START, WAIT, DONE; all outputs SHALL be registered.
REQ-015 IDLE: if any req bit is set, the block SHALL pick the first set bit scanning from (last_grant+1) mod NUM_REQ upward with wrap, latch grant_id and tx_byte, and move to START; otherwise it SHALL stay in IDLE.
REQ-016 START: tx_en SHALL be 0 for exactly one cycle, then the FSM SHALL move to WAIT.
REQ-017 WAIT: tx_complete=1 SHALL move the FSM to DONE; tx_complete outside WAIT SHALL be ignored.
REQ-018 DONE: ack[grant_id] SHALL be 1 for exactly one cycle, last_grant SHALL be set to grant_id, and the FSM SHALL return to IDLE.
REQ-019 Latency: req sampled in IDLE at edge N SHALL give tx_en=0 during cycle N+1; tx_complete sampled at edge M SHALL give ack high during cycle M+1.
REQ-020 Minimum turnaround between consecutive grants SHALL be one IDLE cycle; a requester that holds req after its ack SHALL be rescheduled only in round-robin order.
REQ-021 tx_byte and grant_id SHALL remain stable from START through DONE, regardless of changes on req or req_byte.
REQ-022 If req drops during START or WAIT, the transfer SHALL still complete and ack SHALL still pulse.
REQ-023 Simultaneous requests SHALL be resolved by round-robin only; no requester SHALL wait more than NUM_REQ-1 grants.
REQ-024 At most one ack bit SHALL be high in any cycle.

Reset
REQ-025 reset=1 at any edge, including mid-transfer, SHALL force: state IDLE, tx_en=1, tx_byte=0, ack=0, grant_id=0, busy=0, timeout_err=0, last_grant=NUM_REQ-1, so that req[0] has first priority.
REQ-026 reset SHALL take precedence over every other input in the same cycle.

Configuration
REQ-027 Macro UART_TX_SCHED_TIMEOUT_EN defined: a counter SHALL clear on entry to WAIT; if it reaches TIMEOUT_CYCLES without tx_complete, the FSM SHALL go to IDLE with no ack, set timeout_err (sticky until reset), and set last_grant to grant_id.
REQ-028 Macro UART_TX_SCHED_TIMEOUT_EN undefined: WAIT SHALL wait indefinitely, and timeout_err SHALL be tied to 0; the port list SHALL be unchanged.

Verification
REQ-029 Single request: req=4'b0001, byte 0x4F; tx_complete pulsed 20 cycles after tx_en low -> one tx_en low cycle, tx_byte=0x4F, ack=4'b0001 one cycle later, busy falls.
REQ-030 Round-robin: req=4'b1111 held, bytes 0x30..0x33 -> grants in order 0,1,2,3,0, with exactly one ack per transfer.
REQ-031 Wrap: after grant 2, req=4'b0011 -> next grant 0, then 1.
REQ-032 Stray/early done: tx_complete pulsed in IDLE and in START -> ignored; FSM stays in WAIT until the next tx_complete.
REQ-033 Reset mid-WAIT with req=4'b0100 -> next cycle shows IDLE, tx_en=1, ack=0; after release, requester 2 is granted and completes normally.
REQ-034 With UART_TX_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=16, no tx_complete -> IDLE after 16 WAIT cycles, timeout_err=1, no ack; the next requester is then served.
